// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the PC clock-enable generator.
// FSM state encoding plus board and simulation timing defaults.
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        S_STOP = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam int DIV_BOARD       = 50000;
    localparam int DB_CYCLES_BOARD = 250000;

    localparam int DIV_SIM         = 4;
    localparam int DB_CYCLES_SIM   = 8;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop sync, optional stable-level
// filter (STEP_DEBOUNCE_EN) and a one-clk rising-edge pulse.
// Ports: clk, reset (async, active-high), i_btn (async raw
// button), o_rise (one-clk pulse on an accepted press).
module btn_debounce
    import clk_ctrl_pkg::*;
#(
    parameter int DB_WIDTH  = 18,
    parameter int DB_CYCLES = DB_CYCLES_BOARD
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_rise
);

    logic r_sync_meta;
    logic r_sync;
    logic r_prev;
    logic w_level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_meta <= 1'b0;
            r_sync      <= 1'b0;
        end else begin
            r_sync_meta <= i_btn;
            r_sync      <= r_sync_meta;
        end
    end

`ifdef STEP_DEBOUNCE_EN
    localparam logic [DB_WIDTH-1:0] DB_LAST =
        DB_WIDTH'(DB_CYCLES - 1);

    logic [DB_WIDTH-1:0] r_cnt;
    logic                r_level;

    // The accepted level follows the synced input only after
    // it has differed for DB_CYCLES consecutive samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (r_sync == r_level) begin
            r_cnt   <= '0;
        end else if (r_cnt == DB_LAST) begin
            r_cnt   <= '0;
            r_level <= r_sync;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign w_level = r_level;
`else
    logic [DB_WIDTH-1:0] w_unused_db;
    assign w_unused_db = DB_WIDTH'(DB_CYCLES);
    assign w_level     = r_sync;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_rise = w_level & ~r_prev;

endmodule

// File: rtl/clock_tick_gen.sv
// Program-counter clock-enable generator: RUN / STOP+STEP /
// sticky HALT. Step debounce built when STEP_DEBOUNCE_EN.
// Ports: clk, reset (async, active-high), run_sw, step_btn
// (async), halt (sync strobe); tick (registered enable pulse),
// running (state==S_RUN), halted (state==S_HALT).
module clock_tick_gen
    import clk_ctrl_pkg::*;
#(
    parameter int DIV_WIDTH = 16,
    parameter int DIV       = DIV_BOARD,
    parameter int DB_WIDTH  = 18,
    parameter int DB_CYCLES = DB_CYCLES_BOARD
) (
    input  logic clk,
    input  logic reset,
    input  logic run_sw,
    input  logic step_btn,
    input  logic halt,
    output logic tick,
    output logic running,
    output logic halted
);

    localparam logic [DIV_WIDTH-1:0] DIV_LAST =
        DIV_WIDTH'(DIV - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DIV_WIDTH-1:0] r_presc;
    logic [DIV_WIDTH-1:0] w_presc_nxt;
    logic                 r_tick;
    logic                 w_tick_nxt;
    logic                 r_run_meta;
    logic                 r_run_s;
    logic                 w_step_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run_meta <= 1'b0;
            r_run_s    <= 1'b0;
        end else begin
            r_run_meta <= run_sw;
            r_run_s    <= r_run_meta;
        end
    end

    btn_debounce #(
        .DB_WIDTH  (DB_WIDTH),
        .DB_CYCLES (DB_CYCLES)
    ) u_step_db (
        .clk    (clk),
        .reset  (reset),
        .i_btn  (step_btn),
        .o_rise (w_step_rise)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_STOP;
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    // Priority: halt > run_sw > step > prescaler.
    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_tick_nxt  = 1'b0;
        case (r_state)
            S_STOP: begin
                if (halt) begin
                    w_state_nxt = S_HALT;
                end else if (r_run_s) begin
                    w_state_nxt = S_RUN;
                    w_presc_nxt = '0;
                end else if (w_step_rise) begin
                    w_tick_nxt  = 1'b1;
                end
            end
            S_RUN: begin
                if (halt) begin
                    w_state_nxt = S_HALT;
                end else if (!r_run_s) begin
                    w_state_nxt = S_STOP;
                    w_presc_nxt = '0;
                end else if (r_presc == DIV_LAST) begin
                    w_presc_nxt = '0;
                    w_tick_nxt  = 1'b1;
                end else begin
                    w_presc_nxt = r_presc + 1'b1;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_STOP;
                w_presc_nxt = '0;
            end
        endcase
    end

    assign tick    = r_tick;
    assign running = (r_state == S_RUN);
    assign halted  = (r_state == S_HALT);

endmodule

// File: tb/tb_clock_tick_gen.sv
// Directed bench for clock_tick_gen (DIV=4, DB_CYCLES=8).
// Step timing expectations follow STEP_DEBOUNCE_EN.
module tb_clock_tick_gen;
    import clk_ctrl_pkg::*;

`ifdef STEP_DEBOUNCE_EN
    localparam int DBL = DB_CYCLES_SIM;
`else
    localparam int DBL = 0;
`endif
    localparam int STEP_AT = 2 + DBL;

    typedef struct {
        logic run_sw;
        logic step;
        logic halt;
        logic e_tick;
        logic e_run;
        logic e_halt;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic run_sw;
    logic step_btn;
    logic halt;
    logic tick;
    logic running;
    logic halted;

    int   total = 0;
    int   bad   = 0;
    vec_t tbl[$];
    int   on_base, on_len;
    int   off_base, off_len;

    always #5 clk = ~clk;

    clock_tick_gen #(
        .DIV_WIDTH (16),
        .DIV       (DIV_SIM),
        .DB_WIDTH  (18),
        .DB_CYCLES (DB_CYCLES_SIM)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .run_sw   (run_sw),
        .step_btn (step_btn),
        .halt     (halt),
        .tick     (tick),
        .running  (running),
        .halted   (halted)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm,
                       input logic act,
                       input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic chk3(input string nm,
                        input logic et,
                        input logic er,
                        input logic eh);
        chk({nm, ".tick"}, tick, et);
        chk({nm, ".running"}, running, er);
        chk({nm, ".halted"}, halted, eh);
    endtask

    function automatic vec_t mk(logic r, logic s,
                                logic h, logic et,
                                logic er, logic eh);
        vec_t v;
        v.run_sw = r;
        v.step   = s;
        v.halt   = h;
        v.e_tick = et;
        v.e_run  = er;
        v.e_halt = eh;
        return v;
    endfunction

    task automatic run_seg(input string nm,
                           input int base,
                           input int n);
        for (int i = 0; i < n; i++) begin
            run_sw   = tbl[base+i].run_sw;
            step_btn = tbl[base+i].step;
            halt     = tbl[base+i].halt;
            cyc();
            chk3(nm, tbl[base+i].e_tick,
                 tbl[base+i].e_run, tbl[base+i].e_halt);
        end
    endtask

    task automatic press(input string nm, input int hi,
                         input int lo, input int at);
        for (int i = 0; i < hi + lo; i++) begin
            step_btn = (i < hi);
            cyc();
            chk3(nm, (i == at), 1'b0, 1'b0);
        end
    endtask

    initial begin
        // run_sw raised: 3 clk to S_RUN, ticks 4 clk later
        on_base = tbl.size();
        for (int i = 0; i < 11; i++)
            tbl.push_back(mk(1, 0, 0,
                             (i == 6 || i == 10),
                             (i >= 2), 0));
        on_len = tbl.size() - on_base;
        // run_sw dropped right after a tick: sync sees 0
        // while prescaler==2, so no tick may follow
        off_base = tbl.size();
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(0, 0, 0, 0, (i < 2), 0));
        off_len = tbl.size() - off_base;

        reset    = 1'b1;
        run_sw   = 1'b0;
        step_btn = 1'b0;
        halt     = 1'b0;
        repeat (5) cyc();
        chk3("in_reset", 0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            chk3("idle", 0, 0, 0);
        end

        run_seg("run_on", on_base, on_len);
        for (int p = 0; p < 10; p++) begin
            for (int c = 0; c < 4; c++) begin
                cyc();
                chk3("period", (c == 3), 1, 0);
            end
        end

        run_seg("run_off", off_base, off_len);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk3("stopped", 0, 0, 0);
        end

        press("glitch1", 3, 3, (DBL == 0) ? STEP_AT : -1);
        press("glitch2", 3, 3, (DBL == 0) ? STEP_AT : -1);
        press("step", 20, 14, STEP_AT);

        run_seg("rerun", on_base, on_len);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk3("pre_halt", 0, 1, 0);
        end
        halt = 1'b1;
        cyc();
        chk3("halt_sup", 0, 0, 1);
        halt = 1'b0;
        for (int i = 0; i < 100; i++) begin
            run_sw   = 1'($urandom_range(0, 1));
            step_btn = 1'($urandom_range(0, 1));
            cyc();
            chk3("halted", 0, 0, 1);
        end

        run_sw   = 1'b0;
        step_btn = 1'b0;
        #3 reset = 1'b1;
        #1 chk3("halt_clr", 0, 0, 0);
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk3("post_rst", 0, 0, 0);
        end

        run_seg("run_on2", on_base, on_len);
        #2 reset = 1'b1;
        #1 chk3("async_rst", 0, 0, 0);
        cyc();
        chk3("rst_hold", 0, 0, 0);
        reset = 1'b0;
        run_seg("restart", on_base, on_len);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
